// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the conditional ALU issue sequencer.
// Holds the operation/condition/state encodings and the ARM-style condition evaluator.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_ORR = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // The reserved 1111 encoding behaves as "always" rather than "never".
    function automatic logic cond_pass(input cond_e cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[NZCV_N];
        z = nzcv[NZCV_Z];
        c = nzcv[NZCV_C];
        v = nzcv[NZCV_V];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_core_n.sv
// Combinational N-bit ALU producing the result and its N/Z/C/V flags.
// Subtraction reuses the adder as a + ~b + 1 so carry means "no borrow".
module alu_core_n
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_e      op,
    output logic [N-1:0] result,
    output logic         n,
    output logic         z,
    output logic         c,
    output logic         v
);

    logic [N-1:0] b_eff;
    logic [N:0]   sum;
    logic         is_sub;

    always_comb begin
        is_sub = (op == OP_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result = sum[N-1:0];
                c      = sum[N];
                v      = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_AND:  result = a & b;
            OP_ORR:  result = a | b;
            default: result = '0;
        endcase
        n = result[N-1];
        z = (result == '0);
    end

endmodule

// File: rtl/alu_cond_sequencer.sv
// Multi-cycle issue controller: accepts one ALU op, evaluates its condition
// against the architectural NZCV register it owns, and returns a registered response.
module alu_cond_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic [3:0]   req_cond,
    input  logic         req_setf,
    input  logic         flush,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_exec,
    output logic [3:0]   nzcv,
    output logic         busy
);

    state_e       state, state_next;
    alu_op_e      op_q;
    cond_e        cond_q;
    logic [N-1:0] a_q, b_q;
    logic         setf_q;

    logic [N-1:0] alu_result;
    logic         alu_n, alu_z, alu_c, alu_v;
    logic         pass;

    alu_core_n #(.N(N)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .n      (alu_n),
        .z      (alu_z),
        .c      (alu_c),
        .v      (alu_v)
    );

    assign pass = cond_pass(cond_q, nzcv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // flush wins over both a new request and a pending response handshake
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!flush && req_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = flush ? ST_IDLE : ST_DONE;
            ST_DONE: if (flush || res_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            cond_q    <= COND_EQ;
            a_q       <= '0;
            b_q       <= '0;
            setf_q    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_exec  <= 1'b0;
            nzcv      <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!flush && req_valid) begin
                        op_q   <= alu_op_e'(req_op);
                        cond_q <= cond_e'(req_cond);
                        a_q    <= req_a;
                        b_q    <= req_b;
                        setf_q <= req_setf;
                    end
                end
                ST_EXEC: begin
                    if (!flush) begin
                        res_valid <= 1'b1;
                        res_exec  <= pass;
                        res_data  <= pass ? alu_result : '0;
                        if (pass && setf_q) begin
                            nzcv <= {alu_n, alu_z, alu_c, alu_v};
                        end
                    end
                end
                ST_DONE: begin
                    if (flush || res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: res_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cond_sequencer.sv
// Self-checking bench for alu_cond_sequencer: expected responses come from an
// independent integer model and are queued at accept time, then popped on each response.
module tb_alu_cond_sequencer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_cond;
    logic         req_setf;
    logic         flush;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_exec;
    logic [3:0]   nzcv;
    logic         busy;

    typedef struct {
        logic [W-1:0] data;
        logic         exec;
        logic [3:0]   flags;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] modelNzcv;
    int         errCount;
    int         checkCount;

    alu_cond_sequencer #(.N(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cond  (req_cond),
        .req_setf  (req_setf),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_exec  (res_exec),
        .nzcv      (nzcv),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference flags from signed/unsigned integer ranges rather than adder bits
    function automatic void modelAlu(input int op, input int a, input int b,
                                     output int res, output logic [3:0] f);
        int sa, sb, sr;
        logic c, v;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            0: begin res = (a + b) % 16; c = (a + b) > 15; sr = sa + sb; v = (sr > 7) || (sr < -8); end
            1: begin res = (a - b + 16) % 16; c = (a >= b); sr = sa - sb; v = (sr > 7) || (sr < -8); end
            2: res = a & b;
            default: res = a | b;
        endcase
        f = {res >= 8, res == 0, c, v};
    endfunction

    function automatic logic modelCond(input int cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            0: return z;
            1: return !z;
            2: return c;
            3: return !c;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            8: return c && !z;
            9: return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic pushExpected(input int op, input int a, input int b, input int cond, input logic setf);
        int res;
        logic [3:0] f;
        logic pass;
        exp_t e;
        modelAlu(op, a, b, res, f);
        pass = modelCond(cond, modelNzcv);
        if (pass && setf) modelNzcv = f;
        e.data  = pass ? W'(res) : '0;
        e.exec  = pass;
        e.flags = modelNzcv;
        sb.push_back(e);
    endtask

    // Drives one request at a negedge once req_ready shows; returns at the negedge after the accept edge
    task automatic applyStimulus(input int op, input int a, input int b, input int cond,
                                 input logic setf, input logic expectResp);
        int waited;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reqReadyWait", req_ready, 1);
        req_op    = op[1:0];
        req_a     = a[W-1:0];
        req_b     = b[W-1:0];
        req_cond  = cond[3:0];
        req_setf  = setf;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (expectResp) pushExpected(op, a, b, cond, setf);
    endtask

    task automatic waitResponse(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("resValidSeen", res_valid, 1);
    endtask

    task automatic checkResponse(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_data"}, res_data, e.data);
            checkOutput({tag, "_exec"}, res_exec, e.exec);
            checkOutput({tag, "_nzcv"}, nzcv, e.flags);
        end
    endtask

    task automatic releaseResponse(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput({tag, "_idle"}, {res_valid, busy, req_ready}, 3'b001);
    endtask

    task automatic runOp(input string tag, input int op, input int a, input int b,
                         input int cond, input logic setf);
        int lat;
        applyStimulus(op, a, b, cond, setf, 1'b1);
        waitResponse(lat);
        checkOutput({tag, "_latency"}, lat, 1);
        checkResponse(tag);
        releaseResponse(tag);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held;
        errCount   = 0;
        checkCount = 0;
        modelNzcv  = 4'b0000;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_cond   = 4'b1110;
        req_setf   = 1'b0;
        flush      = 1'b0;
        res_ready  = 1'b0;
        #3 rst_n = 1'b0;
        #1 checkOutput("resetOutputs", {req_ready, res_valid, res_data, res_exec, nzcv, busy},
                       {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("afterRelease", {req_ready, res_valid, busy, nzcv}, {1'b1, 1'b0, 1'b0, 4'h0});

        $display("[TB] directed ops");
        runOp("add7p1", 0, 4'b0111, 4'b0001, 14, 1'b1);
        runOp("sub3m3", 1, 4'b0011, 4'b0011, 14, 1'b1);
        runOp("orr5a", 3, 4'b0101, 4'b1010, 14, 1'b1);
        runOp("sub3m3b", 1, 4'b0011, 4'b0011, 14, 1'b1);
        runOp("andEQ", 2, 4'b1100, 4'b1010, 0, 1'b0);
        runOp("andNE", 2, 4'b1100, 4'b1010, 1, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(0, 4'b0010, 4'b0011, 14, 1'b1, 1'b1);
        waitResponse(lat);
        checkResponse("bp1");
        held      = res_data;
        req_op    = 2'b01;
        req_a     = 4'b0001;
        req_b     = 4'b0100;
        req_cond  = 4'b1110;
        req_setf  = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bpHold", {res_valid, req_ready, res_data}, {1'b1, 1'b0, held});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("bpIdle", {res_valid, req_ready}, 2'b01);
        pushExpected(1, 4'b0001, 4'b0100, 14, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("bpAccepted", busy, 1);
        waitResponse(lat);
        checkOutput("bp2_latency", lat, 1);
        checkResponse("bp2");
        releaseResponse("bp2");

        $display("[TB] flush cases");
        applyStimulus(1, 4'b0000, 4'b0001, 14, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flushExec", {res_valid, busy, nzcv}, {1'b0, 1'b0, modelNzcv});
        @(negedge clk);
        @(negedge clk);
        checkOutput("flushNoResp", {res_valid, nzcv}, {1'b0, modelNzcv});
        applyStimulus(0, 4'b0001, 4'b0001, 14, 1'b1, 1'b1);
        waitResponse(lat);
        void'(sb.pop_front());
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flushDone", {res_valid, busy, nzcv}, {1'b0, 1'b0, modelNzcv});
        req_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        checkOutput("flushIdlePrio", busy, 0);

        $display("[TB] random ops");
        for (int i = 0; i < 24; i++) begin
            runOp("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] async reset in DONE");
        applyStimulus(0, 4'b0011, 4'b0100, 14, 1'b1, 1'b1);
        waitResponse(lat);
        #2 rst_n = 1'b0;
        #1 checkOutput("rstDone", {res_valid, nzcv, busy, req_ready}, {1'b0, 4'h0, 1'b0, 1'b1});
        void'(sb.pop_front());
        modelNzcv = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp("add8p8", 0, 4'b1000, 4'b1000, 14, 1'b1);

        checkOutput("sbDrained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_cond_sequencer.md
# alu_cond_sequencer

Multi-cycle issue controller for the N-bit flag-generating ALU. It accepts one operation at a time over a valid/ready request port and evaluates an ARM-style condition code against an architectural NZCV register. It drives the ALU, conditionally updates NZCV, and returns the result over a valid/ready response port. It sits between the decode/control stage and the ALU/flags datapath, and owns the only copy of the status flags.

## Interface
- N, 4: operand/result width (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_op  in  2  ALUControl: 00 ADD, 01 SUB, 10 AND, 11 ORR
- req_a, req_b  in  N  operands
- req_cond  in  4  condition code
- req_setf  in  1  update NZCV if executed
- flush  in  1  synchronous abort of in-flight op
- res_valid  out  1  response present
- res_ready  in  1  consumer accepts response
- res_data  out  N  result (0 if not executed)
- res_exec  out  1  condition passed
- nzcv  out  4  {N,Z,C,V} status register
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, DONE. Reset → IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/a/b/cond/setf and go to EXEC.
- EXEC:
  - Evaluate the condition against the current nzcv.
  - Capture the ALU result and flags.
  - Go to DONE.
- DONE:
  - res_valid=1.
  - On res_ready, go to IDLE.
  - Without res_ready, hold res_data/res_exec stable.
- Conditions: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as AL.
- Flag rules:
  - N = result[N-1]; Z = (result==0).
  - ADD: C = carry-out of a+b.
  - SUB: computed as a+~b+1; C = carry-out (1 = no borrow).
  - V (ADD/SUB): set when operand signs agree and the result sign differs; for SUB the compared signs are a and ~b.
  - AND/ORR: C=0, V=0.
- nzcv is written only in EXEC, and only if the condition passed and setf=1. Otherwise it is unchanged.
- A failed condition gives res_data=0 and res_exec=0. It still produces a response.
- flush:
  - In EXEC or DONE, go to IDLE next edge with no response and no nzcv write. If the capture edge coincides with flush, the write is suppressed.
  - In IDLE, flush has priority over accepting a request.
- Results wrap modulo 2^N. The carry is the (N+1)th bit.

## Timing
- Reset values: req_ready=1 after reset release, res_valid=0, res_data=0, res_exec=0, nzcv=0000, busy=0.
- Accept at edge t → EXEC during cycle t..t+1 → res_valid=1 from edge t+1. Latency is 2 edges from accept to response accepted, minimum.
- Throughput: at most one op per 3 cycles. IDLE is always re-entered for one cycle.
- nzcv is visible updated from edge t+1, the same cycle res_valid rises.
- res_valid, res_data and res_exec are registered outputs. req_ready and busy decode the registered state only, with no combinational path from inputs.
- Async rst_n in any state:
  - Immediately forces all outputs to their reset values.
  - The in-flight op is lost.

## Structure
- Package alu_seq_pkg: alu_op_e (ADD/SUB/AND/ORR), cond_e (16 codes), state_e (IDLE/EXEC/DONE), NZCV bit-index constants.
- Sub-module alu_core_n #(N): combinational result and flags (n, z, c, v) from a, b, op. It is instantiated once.
- cond_pass is a function in alu_seq_pkg.

## Test plan
1. ADD a=0111 b=0001 setf=1 cond=AL → res_data=1000, res_exec=1, nzcv=1001, res_valid 1 edge after accept.
2. SUB a=0011 b=0011 setf=1 AL → res_data=0000, nzcv=0110. Then ORR a=0101 b=1010 setf=1 AL → res_data=1111, nzcv=1000 (C, V cleared).
3. With nzcv=0110:
   - AND a=1100 b=1010 cond=EQ setf=0 → res_data=1000, res_exec=1, nzcv stays 0110.
   - Same op with cond=NE → res_data=0000, res_exec=0, nzcv unchanged.
4. Backpressure: hold res_ready=0 for 3 cycles in DONE while req_valid=1 → res_data stable, req_ready=0, no second accept. res_ready=1 → IDLE next edge, then the new request is accepted.
5. flush asserted during EXEC of SUB 0000-0001 setf=1 → no res_valid, nzcv unchanged, IDLE next edge.
6. rst_n low mid-DONE → res_valid=0, nzcv=0000, busy=0 immediately. After release, ADD 1000+1000 setf=1 → res_data=0000, nzcv=0111.
